// File: rtl/dpram_port_arbiter_pkg.sv
// Shared types and helpers for the dual-port SRAM port arbiter.
// Holds the access-sequencer state encoding and the default SRAM geometry.
package dpram_arb_pkg;

  localparam int SRAM_ADDR_W = 5;
  localparam int SRAM_DATA_W = 32;
  localparam int MAX_REQ     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    REL  = 2'd2
  } arb_state_e;

  // The pointer starts on the last requester so requester 0 wins first.
  function automatic int rr_ptr_rst(input int num_req);
    return num_req - 1;
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: searches from ptr+1 upward,
// wrapping modulo NUM_REQ, and returns a one-hot grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic            found_s;
  int              idx_int;
  logic [ID_W-1:0] idx_s;

  // First requester after the pointer wins; later ones are masked by found_s.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    idx_int = 0;
    idx_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_int       = (int'(ptr_i) + i) % NUM_REQ;
      idx_s         = ID_W'(idx_int);
      gnt_o[idx_s]  = gnt_o[idx_s] | (enable_i & req_i[idx_s] & ~found_s);
      found_s       = found_s | (enable_i & req_i[idx_s]);
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter and CEB/WEB/OEB strobe sequencer sharing one SRAM
// macro port between NUM_REQ requesters; reads return on a tagged channel.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      rsp_valid_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      busy_o,
  output logic [ADDR_W-1:0]         ram_a_o,
  output logic [DATA_W-1:0]         ram_i_o,
  input  logic [DATA_W-1:0]         ram_o_i,
  output logic                      ram_ceb_o,
  output logic                      ram_web_o,
  output logic                      ram_oeb_o
);

  localparam logic [ID_W-1:0] PTR_RST = ID_W'(rr_ptr_rst(NUM_REQ));

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                ceb_q, ceb_d;
  logic                web_q, web_d;
  logic                oeb_q, oeb_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]  gnt_s;
  logic                hs_s;
  logic [ID_W-1:0]     winner_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .enable_i (state_q == IDLE),
    .gnt_o    (gnt_s)
  );

  assign hs_s     = |gnt_s;
  assign winner_s = ID_W'(onehot_idx(MAX_REQ'(gnt_s)));

  // Next-state and strobe sequencing; strobes are registered so the macro
  // sees glitch-free CEB/WEB/OEB, and the ACC->REL edge is the CEB rise.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    ceb_d       = 1'b1;
    web_d       = 1'b1;
    oeb_d       = 1'b1;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          state_d = ACC;
          ptr_d   = winner_s;
          addr_d  = req_addr_i[winner_s*ADDR_W +: ADDR_W];
          wdata_d = req_wdata_i[winner_s*DATA_W +: DATA_W];
          we_d    = req_we_i[winner_s];
          ceb_d   = 1'b0;
          web_d   = ~req_we_i[winner_s];
          oeb_d   = req_we_i[winner_s];
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        state_d = REL;
        oeb_d   = oeb_q;
      end
      REL: begin
        state_d     = IDLE;
        rsp_valid_d = ~we_q;
        rsp_id_d    = we_q ? rsp_id_q : ptr_q;
        rsp_rdata_d = we_q ? rsp_rdata_q : ram_o_i;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset parks every strobe inactive.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_RST;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      ceb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      ceb_q       <= ceb_d;
      web_q       <= web_d;
      oeb_q       <= oeb_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o = gnt_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign busy_o      = busy_q;
  assign ram_a_o     = addr_q;
  assign ram_i_o     = wdata_q;
  assign ram_ceb_o   = ceb_q;
  assign ram_web_o   = web_q;
  assign ram_oeb_o   = oeb_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench for dpram_port_arbiter: behavioural SRAM macro,
// table-driven grant vectors, a read-response scoreboard and corner sequences.
module tb_dpram_port_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_we;
  logic [19:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_rdata;
  logic         busy;
  logic [4:0]   ram_a;
  logic [31:0]  ram_i;
  logic [31:0]  ram_o;
  logic         ram_ceb;
  logic         ram_web;
  logic         ram_oeb;

  dpram_port_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_rdata_o (rsp_rdata),
    .busy_o      (busy),
    .ram_a_o     (ram_a),
    .ram_i_o     (ram_i),
    .ram_o_i     (ram_o),
    .ram_ceb_o   (ram_ceb),
    .ram_web_o   (ram_web),
    .ram_oeb_o   (ram_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: an access commits on the clock edge where CEB rises.
  logic [31:0] mem [0:31];
  logic [31:0] rd_q;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rd_q = 32'h0;
  end
  always @(posedge clk) begin
    if (!ram_ceb) begin
      if (!ram_web) mem[ram_a] <= ram_i;
      else          rd_q       <= mem[ram_a];
    end
  end
  assign ram_o = ram_oeb ? 32'h0 : rd_q;

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   we;
    logic [19:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   exp_ready;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sb [$];
  logic [31:0] ref_mem [0:31];
  int          checks;
  int          errors;
  int          cyc;
  int          ceb_low_cnt;
  int          gnt2_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'h0);
  endtask

  initial begin
    int c0;
    int g0;
    rst       = 1'b0;
    req_valid = 4'b0;
    req_we    = 4'b0;
    req_addr  = 20'h0;
    req_wdata = 128'h0;
    checks = 0; errors = 0; cyc = 0; ceb_low_cnt = 0; gnt2_cnt = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    vecs[0] = '{4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 4'b0001};
    vecs[1] = '{4'b0001, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd5}, 128'h0, 4'b0001};
    vecs[2] = '{4'b0100, 4'b0000, {5'd0, 5'd7, 5'd0, 5'd0}, 128'h0, 4'b0100};
    vecs[3] = '{4'b1010, 4'b0000, {5'd31, 5'd0, 5'd3, 5'd0}, 128'h0, 4'b1000};
    vecs[4] = '{4'b1010, 4'b0000, {5'd31, 5'd0, 5'd3, 5'd0}, 128'h0, 4'b0010};
    vecs[5] = '{4'b0000, 4'b0000, 20'h0, 128'h0, 4'b0000};
    vecs[6] = '{4'b1111, 4'b1111, {5'd3, 5'd2, 5'd1, 5'd0},
                {32'hA3A30003, 32'hA2A20002, 32'hA1A10001, 32'hA0A00000}, 4'b0100};
    vecs[7] = '{4'b1111, 4'b0000, {5'd3, 5'd2, 5'd1, 5'd0}, 128'h0, 4'b1000};
    vecs[8] = '{4'b1111, 4'b0100, {5'd3, 5'd2, 5'd1, 5'd0},
                {32'h0, 32'h12345678, 32'h0, 32'h0}, 4'b0001};
    vecs[9] = '{4'b0011, 4'b0011, {5'd0, 5'd0, 5'd12, 5'd11},
                {32'h0, 32'h0, 32'hCAFE0012, 32'hCAFE0011}, 4'b0010};

    fork
      // Watchdog so the run always ends.
      begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
      // Handshake monitor: predicts read responses from the bench memory.
      forever begin
        @(posedge clk);
        if (rst) begin
          sb.delete();
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
              if (i == 2) gnt2_cnt++;
              if (req_we[i]) begin
                ref_mem[req_addr[i*5 +: 5]] = req_wdata[i*32 +: 32];
              end else begin
                sb.push_back('{2'(i), ref_mem[req_addr[i*5 +: 5]], cyc + 3});
              end
            end
          end
        end
        if (!ram_ceb) ceb_low_cnt++;
        cyc++;
      end
      // Response checker and strobe exclusivity.
      forever begin
        exp_t e;
        @(negedge clk);
        check("web_oeb_excl", 32'(ram_web | ram_oeb), 32'h1);
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            check("rsp_spurious", 32'(rsp_valid), 32'h0);
          end else begin
            e = sb.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_rdata", rsp_rdata, e.data);
            check("rsp_latency", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    join_none

    // Reset state.
    #1 rst = 1'b1;
    #2;
    check("rst_ceb", 32'(ram_ceb), 32'h1);
    check("rst_web", 32'(ram_web), 32'h1);
    check("rst_oeb", 32'(ram_oeb), 32'h1);
    check("rst_ram_a", 32'(ram_a), 32'h0);
    check("rst_ram_i", ram_i, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Grant vectors, each applied from IDLE.
    for (int k = 0; k < 10; k++) begin
      wait_idle();
      req_valid = vecs[k].valid;
      req_we    = vecs[k].we;
      req_addr  = vecs[k].addr;
      req_wdata = vecs[k].wdata;
      #1 check($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
      @(negedge clk);
      req_valid = 4'b0;
    end
    wait_idle();
    repeat (5) @(negedge clk);

    // Round robin from reset with all four holding reads.
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    req_valid = 4'b1111;
    req_we    = 4'b0000;
    req_addr  = {5'd3, 5'd2, 5'd1, 5'd0};
    for (int c = 0; c < 13; c++) begin
      #1 check($sformatf("rr_c%0d_ready", c), 32'(req_ready),
               32'((c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0));
      @(negedge clk);
    end
    req_valid = 4'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Back-to-back write then read by req1 at address 31, with strobe timing.
    req_valid = 4'b0010;
    req_we    = 4'b0010;
    req_addr  = {5'd0, 5'd0, 5'd31, 5'd0};
    req_wdata = {32'h0, 32'h0, 32'h00000001, 32'h0};
    #1 check("b2b_wr_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0;
    check("b2b_t1_busy", 32'(busy), 32'h1);
    check("b2b_t1_ceb", 32'(ram_ceb), 32'h0);
    check("b2b_t1_web", 32'(ram_web), 32'h0);
    check("b2b_t1_oeb", 32'(ram_oeb), 32'h1);
    check("b2b_t1_ram_a", 32'(ram_a), 32'd31);
    check("b2b_t1_ram_i", ram_i, 32'h1);
    @(negedge clk);
    check("b2b_t2_busy", 32'(busy), 32'h1);
    check("b2b_t2_ceb", 32'(ram_ceb), 32'h1);
    check("b2b_t2_web", 32'(ram_web), 32'h1);
    check("b2b_t2_ram_a", 32'(ram_a), 32'd31);
    @(negedge clk);
    check("b2b_t3_busy", 32'(busy), 32'h0);
    req_valid = 4'b0010;
    req_we    = 4'b0000;
    #1 check("b2b_rd_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0;
    check("b2b_t4_busy", 32'(busy), 32'h1);
    check("b2b_t4_ceb", 32'(ram_ceb), 32'h0);
    check("b2b_t4_web", 32'(ram_web), 32'h1);
    check("b2b_t4_oeb", 32'(ram_oeb), 32'h0);
    @(negedge clk);
    check("b2b_t5_busy", 32'(busy), 32'h1);
    check("b2b_t5_ceb", 32'(ram_ceb), 32'h1);
    check("b2b_t5_oeb", 32'(ram_oeb), 32'h0);
    @(negedge clk);
    check("b2b_t6_rsp_valid", 32'(rsp_valid), 32'h1);
    check("b2b_t6_rsp_id", 32'(rsp_id), 32'h1);
    check("b2b_t6_rsp_rdata", rsp_rdata, 32'h00000001);
    check("b2b_t6_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);

    // Reset during ACC of a req2 read.
    req_valid = 4'b0100;
    req_we    = 4'b0000;
    req_addr  = {5'd0, 5'd7, 5'd0, 5'd0};
    #1 check("rstacc_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0;
    check("rstacc_in_acc", 32'(ram_ceb), 32'h0);
    rst = 1'b1;
    #1;
    check("rstacc_ceb", 32'(ram_ceb), 32'h1);
    check("rstacc_web", 32'(ram_web), 32'h1);
    check("rstacc_oeb", 32'(ram_oeb), 32'h1);
    check("rstacc_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rstacc_busy", 32'(busy), 32'h0);
    check("rstacc_ram_a", 32'(ram_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstacc_no_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    req_valid = 4'b1111;
    req_we    = 4'b0000;
    req_addr  = {5'd3, 5'd2, 5'd1, 5'd0};
    #1 check("rstacc_next_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // req2 valid for one busy cycle then withdrawn.
    c0 = ceb_low_cnt;
    g0 = gnt2_cnt;
    req_valid = 4'b0001;
    req_we    = 4'b0001;
    req_addr  = {5'd0, 5'd0, 5'd0, 5'd9};
    req_wdata = {32'h0, 32'h0, 32'h0, 32'h00000055};
    #1 check("wd_req0_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0100;
    req_we    = 4'b0000;
    req_addr  = {5'd0, 5'd4, 5'd0, 5'd0};
    #1 check("wd_busy_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = 4'b0;
    #1 check("wd_after_ready", 32'(req_ready), 32'h0);
    repeat (6) @(negedge clk);
    check("wd_strobe_count", 32'(ceb_low_cnt - c0), 32'h1);
    check("wd_gnt2_count", 32'(gnt2_cnt - g0), 32'h0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
